mod_step_counter: RTL
=====================

// Module: mod_step_counter
// PURPOSE
//  Modulo-N up/down counter with programmable step, load, wrap/saturate mode,
//  and a built-in tick prescaler. Next generation of the plain free-running
//  enable counter. Used for baud/timer dividers, address generators, event
//  counters. Single clock domain.
// PARAMETERS
//  MOD_VALUE   256  count range 0..MOD_VALUE-1 (>=2)
//  PRESCALE_W  8    width of prescale_i
//  WIDTH       local = $clog2(MOD_VALUE); width of value/step/load
// PORTS
//  clk_i         in   1           clock, all logic on rising edge
//  s_rst_i       in   1           synchronous reset, active-high
//  en_i          in   1           enable; low freezes prescaler and counter
//  dir_i         in   1           1 = count up, 0 = count down
//  mode_i        in   1           counter_pkg::cnt_mode_t: 0 CNT_WRAP, 1 CNT_SAT
//  step_i        in   WIDTH       increment per tick; 0 = hold
//  prescale_i    in   PRESCALE_W  tick every prescale_i+1 enabled cycles
//  load_i        in   1           load pulse
//  load_value_i  in   WIDTH       value written on load
//  clr_flag_i    in   1           clears wrap_o
//  value_o       out  WIDTH       current count (registered)
//  tc_o          out  1           1-cycle pulse on boundary crossing
//  wrap_o        out  1           sticky: a wrap has occurred
// BEHAVIOUR
//  - Reset: value_o=0, tc_o=0, wrap_o=0, prescaler count=0.
//  - Priority per cycle: s_rst_i > load_i > tick.
//  - Prescaler: pre_cnt increments while en_i=1; tick = en_i && pre_cnt==prescale_i,
//    pre_cnt->0 on tick. prescale_i=0 -> tick every enabled cycle. If prescale_i
//    drops below pre_cnt, tick on pre_cnt>=prescale_i (no 2^W stall).
//  - Load: value_o<=min(load_value_i, MOD_VALUE-1); pre_cnt<=0; tc_o=0; load
//    acts even when en_i=0.
//  - Tick latency: value_o/tc_o/wrap_o update on the edge ending the tick cycle.
//  - Step clamped to MOD_VALUE-1. Sums in WIDTH+1 bits, no silent overflow.
//  - Up: s=value+step. s<MOD -> value=s. Else WRAP: value=s-MOD, tc=1, wrap set;
//    SAT: value=MOD-1, tc=1 only on the tick that first reaches MOD-1.
//  - Down: value>=step -> value-=step. Else WRAP: value=value+MOD-step, tc=1,
//    wrap set; SAT: value=0, tc=1 only on the tick that first reaches 0.
//  - Exact landing on MOD-1 (up) / 0 (down) in WRAP: no tc; tc only on crossing.
//  - step=0: value holds, no tc, no wrap.
//  - wrap_o: set wins over clr_flag_i in the same cycle.
//  - dir_i/mode_i/step_i/prescale_i sampled each tick; mid-count change legal.
//  - Reset mid-operation: all state cleared next edge, regardless of load/tick.
// STRUCTURE
//  - counter_pkg: typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_t;
//    typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_t.
//  - Sub-module tick_prescaler (PRESCALE_W): clk_i, s_rst_i, en_i, clr_i,
//    prescale_i -> tick_o. clr_i driven by load_i.
//  - Top: next-value comb block (clamp, up/down, wrap/sat) + output regs.
// TESTING
//  1 MOD=10,step=3,up,WRAP,prescale=0: 0,3,6,9,2 ; tc_o pulse with 2 ; wrap_o=1.
//  2 MOD=10,step=4,down,SAT from load 9: 9,5,1,0,0 ; tc_o once at 0 only.
//  3 prescale=3,step=1,up: value advances every 4th enabled cycle; en_i low
//    for 5 cycles mid-period -> period resumes, no lost/extra tick.
//  4 load_i=1 with tick same cycle, load_value=15, MOD=10 -> value=9, tc_o=0,
//    pre_cnt=0.
//  5 clr_flag_i and wrap event same cycle -> wrap_o=1; clr alone next -> 0.
//  6 s_rst_i asserted during load and tick -> value_o=0, tc_o=0, wrap_o=0.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the step counter
package counter_pkg;

    // Boundary behaviour when a step would cross 0 or MOD_VALUE-1.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    // Counting direction.
    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_t;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - enable-gated tick divider, one tick per prescale_i+1 enabled cycles
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;
    logic                  at_limit;

    // Using >= rather than == means a prescale value lowered below the
    // running count fires on the next enabled cycle instead of waiting for
    // the counter to roll all the way round. The count never exceeds
    // prescale_i while it is stable, so it cannot overflow.
    assign at_limit = (pre_cnt_q >= prescale_i);
    assign tick_o   = en_i && at_limit;

    // Next prescaler count: restart on clear or tick, advance while enabled.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr_i) begin
            pre_cnt_d = '0;
        end else if (en_i) begin
            if (at_limit) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/mod_step_counter.sv
// rtl/mod_step_counter.sv - modulo-N up/down counter with step, load, wrap/saturate and prescaler
module mod_step_counter
    import counter_pkg::*;
#(
    parameter  int MOD_VALUE  = 256,
    parameter  int PRESCALE_W = 8,
    localparam int WIDTH      = $clog2(MOD_VALUE)
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic                  mode_i,
    input  logic [WIDTH-1:0]      step_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_value_i,
    input  logic                  clr_flag_i,
    output logic [WIDTH-1:0]      value_o,
    output logic                  tc_o,
    output logic                  wrap_o
);

    // Modulus and top count, held one bit wider where sums are formed so
    // value+step and value+MOD never lose a carry.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD_VALUE);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VALUE - 1);

    logic [WIDTH-1:0] value_q, value_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             wrap_set;
    logic             tick;

    cnt_dir_t         dir;
    cnt_mode_t        mode;
    logic [WIDTH-1:0] step_c;
    logic [WIDTH-1:0] load_c;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   sum_dn_wrap;
    logic             up_cross;
    logic             dn_cross;

    assign dir  = cnt_dir_t'(dir_i);
    assign mode = cnt_mode_t'(mode_i);

    // Load clears the prescaler so the first tick after a load comes a full
    // period later.
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_prescaler (
        .clk_i      (clk_i),
        .s_rst_i    (s_rst_i),
        .en_i       (en_i),
        .clr_i      (load_i),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    // Clamp step and load value into range and form the candidate sums.
    always_comb begin
        step_c      = (step_i > MAX_VAL) ? MAX_VAL : step_i;
        load_c      = (load_value_i > MAX_VAL) ? MAX_VAL : load_value_i;
        sum_up      = {1'b0, value_q} + {1'b0, step_c};
        sum_dn_wrap = {1'b0, value_q} + MOD_EXT - {1'b0, step_c};
        up_cross    = (sum_up >= MOD_EXT);
        dn_cross    = (value_q < step_c);
    end

    // Next count, terminal-count pulse and wrap event. Load beats tick;
    // an exact landing on the boundary is not a crossing, and saturation
    // only pulses tc_o on the tick that first arrives at the rail.
    always_comb begin
        value_d  = value_q;
        tc_d     = 1'b0;
        wrap_set = 1'b0;
        if (load_i) begin
            value_d = load_c;
        end else if (tick) begin
            if (dir == CNT_UP) begin
                if (!up_cross) begin
                    value_d = sum_up[WIDTH-1:0];
                end else if (mode == CNT_WRAP) begin
                    value_d  = WIDTH'(sum_up - MOD_EXT);
                    tc_d     = 1'b1;
                    wrap_set = 1'b1;
                end else begin
                    value_d = MAX_VAL;
                    tc_d    = (value_q != MAX_VAL);
                end
            end else begin
                if (!dn_cross) begin
                    value_d = value_q - step_c;
                end else if (mode == CNT_WRAP) begin
                    value_d  = WIDTH'(sum_dn_wrap);
                    tc_d     = 1'b1;
                    wrap_set = 1'b1;
                end else begin
                    value_d = '0;
                    tc_d    = (value_q != '0);
                end
            end
        end
    end

    // Sticky wrap flag: a new wrap in the same cycle wins over a clear.
    always_comb begin
        wrap_d = wrap_q;
        if (wrap_set) begin
            wrap_d = 1'b1;
        end else if (clr_flag_i) begin
            wrap_d = 1'b0;
        end
    end

    // Output registers; reset overrides load and tick.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            value_q <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign value_o = value_q;
    assign tc_o    = tc_q;
    assign wrap_o  = wrap_q;

endmodule : mod_step_counter
